// File: rtl/gen_wave_pkg.sv
// rtl/gen_wave_pkg.sv - mode encodings and phase-length helpers for gen_wave_param
package gen_wave_pkg;

   typedef enum logic [1:0] {
      MODE_PARAB = 2'd0,
      MODE_TRI   = 2'd1,
      MODE_SAW   = 2'd2,
      MODE_SQR   = 2'd3
   } mode_e;

   // Q = samples per quarter period, P = samples per full period
   function automatic int quarter_len(input int n_log);
      return 1 << n_log;
   endfunction

   function automatic int period_len(input int n_log);
      return 4 << n_log;
   endfunction

endpackage

// File: rtl/gen_wave_phase.sv
// rtl/gen_wave_phase.sv - phase counter, wrap detect and one-clk period sync pulse
module gen_wave_phase
   import gen_wave_pkg::*;
#(
   parameter int N_LOG = 4
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               ce_i,
   output logic [N_LOG-1:0]   k_o,
   output logic               desc_o,
   output logic [N_LOG+1:0]   n_nxt_o,
   output logic               wrap_o,
   output logic               sync_o
);

   localparam int P = period_len(N_LOG);
   localparam logic [N_LOG+1:0] N_LAST = (N_LOG+2)'(P - 1);

   logic [N_LOG+1:0] n_q, n_d;
   logic             sync_q, sync_d;

   always_comb begin
      n_d    = ce_i ? n_q + (N_LOG+2)'(1) : n_q;
      wrap_o = ce_i && (n_q == N_LAST);
      sync_d = wrap_o;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         n_q    <= '0;
         sync_q <= 1'b0;
      end else begin
         n_q    <= n_d;
         sync_q <= sync_d;
      end
   end

   // Odd quarters run the magnitude downwards
   assign k_o     = n_q[N_LOG-1:0];
   assign desc_o  = n_q[N_LOG];
   assign n_nxt_o = n_d;
   assign sync_o  = sync_q;

endmodule

// File: rtl/gen_wave_param.sv
// rtl/gen_wave_param.sv - parameterised parabola/triangle/sawtooth/square generator
// with pending-mode switch applied only at period wrap.
module gen_wave_param
   import gen_wave_pkg::*;
#(
   parameter int W     = 10,
   parameter int N_LOG = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ce,
   input  logic [1:0]          mode,
   input  logic                mode_ld,
   output logic signed [W-1:0] wave,
   output logic                sync,
   output logic [1:0]          mode_act
);

   localparam int NB = N_LOG + 2;
   localparam int MW = 2*N_LOG + 1;
   localparam int Q  = quarter_len(N_LOG);
   localparam logic [W-1:0] QSQ = W'(Q*Q);

   logic [N_LOG-1:0]     k_cur;
   logic                 desc_cur;
   logic [NB-1:0]        n_nxt;
   logic                 wrap;

   mode_e                mode_act_q, mode_act_d, pend_mode_q, pend_mode_d;
   logic                 pend_q, pend_d;
   logic [MW-1:0]        mag_q, mag_d;
   logic signed [W-1:0]  wave_q, wave_d;

   logic [N_LOG-1:0]     k_nx;
   logic [N_LOG:0]       k_mir;
   logic [W-1:0]         tri_mag, par_mag;
   logic signed [NB-1:0] saw_base;
   logic signed [W-1:0]  saw_ext;

   gen_wave_phase #(.N_LOG(N_LOG)) u_phase (
      .clk_i   (clk),
      .rst_i   (rst),
      .ce_i    (ce),
      .k_o     (k_cur),
      .desc_o  (desc_cur),
      .n_nxt_o (n_nxt),
      .wrap_o  (wrap),
      .sync_o  (sync)
   );

   // A strobe in the wrapping cycle is folded in before the switch decision
   always_comb begin
      pend_d      = pend_q;
      pend_mode_d = pend_mode_q;
      mode_act_d  = mode_act_q;
      if (mode_ld) begin
         pend_d      = 1'b1;
         pend_mode_d = mode_e'(mode);
      end
      if (wrap && pend_d) begin
         mode_act_d = pend_mode_d;
         pend_d     = 1'b0;
      end
   end

   // Running k^2 / (Q-k)^2 tracked for every mode so a switch lands on a valid value
   always_comb begin
      mag_d = mag_q;
      if (ce) begin
         if (!desc_cur) mag_d = mag_q + MW'({k_cur, 1'b1});
         else           mag_d = mag_q - MW'({~k_cur, 1'b1});
      end
   end

   always_comb begin
      k_nx     = n_nxt[N_LOG-1:0];
      k_mir    = (N_LOG+1)'(Q) - {1'b0, k_nx};
      tri_mag  = n_nxt[N_LOG] ? (W'(k_mir) << N_LOG) : (W'(k_nx) << N_LOG);
      par_mag  = W'(mag_d);
      saw_base = {~n_nxt[NB-1], n_nxt[NB-2:0]};
      saw_ext  = {{(W-NB){saw_base[NB-1]}}, saw_base};
      wave_d   = '0;
      unique case (mode_act_d)
         MODE_PARAB: wave_d = n_nxt[NB-1] ? -$signed(par_mag) : $signed(par_mag);
         MODE_TRI:   wave_d = n_nxt[NB-1] ? -$signed(tri_mag) : $signed(tri_mag);
         MODE_SAW:   wave_d = saw_ext <<< (N_LOG-1);
         MODE_SQR:   wave_d = n_nxt[NB-1] ? -$signed(QSQ) : $signed(QSQ);
         default:    wave_d = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mode_act_q  <= MODE_PARAB;
         pend_mode_q <= MODE_PARAB;
         pend_q      <= 1'b0;
         mag_q       <= '0;
         wave_q      <= '0;
      end else begin
         mode_act_q  <= mode_act_d;
         pend_mode_q <= pend_mode_d;
         pend_q      <= pend_d;
         mag_q       <= mag_d;
         if (ce) wave_q <= wave_d;
      end
   end

   assign wave     = wave_q;
   assign mode_act = mode_act_q;

endmodule

// File: doc/gen_wave_param.md
GEN_WAVE_PARAM -- requirements
Module: gen_wave_param

Interface
REQ-001 Parameter W, default 10: output width in bits, two's complement; SHALL satisfy W >= 2*N_LOG+2.
REQ-002 Parameter N_LOG, default 4: log2 of samples per quarter period; Q = 2^N_LOG, period P = 4Q; SHALL satisfy N_LOG >= 1.
REQ-003 clk  in  1  sole clock; all state on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 ce  in  1  sample-advance enable; one phase step per clk with ce=1.
REQ-006 mode  in  2  requested waveform: 0 parabola, 1 triangle, 2 sawtooth, 3 square.
REQ-007 mode_ld  in  1  one-clk strobe; captures mode as pending.
REQ-008 wave  out  W  signed sample for current phase n.
REQ-009 sync  out  1  one-clk pulse marking the start of a new period.
REQ-010 mode_act  out  2  waveform currently being generated.

Function
REQ-011 Phase counter n, width N_LOG+2, SHALL increment by 1 on each clk with ce=1 and wrap from P-1 to 0; it SHALL hold when ce=0.
REQ-012 With q = n[N_LOG+1:N_LOG] and k = n[N_LOG-1:0], parabola magnitude SHALL be: q0 k^2, q1 (Q-k)^2, q2 k^2, q3 (Q-k)^2.
REQ-013 Parabola sign SHALL be positive in q0/q1 and negative in q2/q3, giving peak +Q^2 at n=Q and -Q^2 at n=3Q.
REQ-014 Triangle SHALL follow the REQ-012/REQ-013 pattern with k*Q and (Q-k)*Q in place of squares.
REQ-015 Sawtooth SHALL be (n-2Q)*(Q/2), range -Q^2 .. Q^2-Q/2.
REQ-016 Square SHALL be +Q^2 for n < 2Q and -Q^2 otherwise.
REQ-017 wave SHALL be registered: on a clk with ce=1, wave SHALL update to f(n+1) in the same edge as n, giving 1-clk latency from ce.
REQ-018 The parabola SHALL be computed incrementally (add/subtract 2k+1 per step, sign applied at output); no multiplier. Triangle/saw/square SHALL use shifts only.
REQ-019 mode_ld=1 SHALL load mode into a pending register and set a pending flag; a second mode_ld before application SHALL overwrite the pending value.
REQ-020 Pending mode SHALL be applied only at wrap (ce=1 with n=P-1): mode_act and wave SHALL switch together on that edge, and wave SHALL equal f_new(0).
REQ-021 mode_ld coinciding with the wrapping ce SHALL take effect at that same wrap, using the mode value sampled in that cycle.
REQ-022 sync SHALL be high for exactly the one clk following each wrap edge, and low otherwise, including when ce is held high continuously.
REQ-023 With ce=0, wave, n, mode_act and sync SHALL hold (sync low). mode_ld SHALL still be captured.

Reset
REQ-024 rst=1 SHALL set n=0, wave=0, mode_act=0 (parabola), pending flag=0 and sync=0; rst SHALL override ce and mode_ld in the same cycle.
REQ-025 rst asserted mid-period SHALL discard the phase and any pending mode; the first ce after release SHALL produce f(1) of parabola.

Structure
REQ-026 Package gen_wave_pkg SHALL hold mode encodings (MODE_PARAB, MODE_TRI, MODE_SAW, MODE_SQR) and the Q/P derivation.
REQ-027 Sub-module gen_wave_phase SHALL hold the phase counter, wrap detect and sync pulse. gen_wave_param SHALL hold the mode handling and sample datapath.

Verification (W=10, N_LOG=4)
REQ-028 Reset, then parabola with ce=1: 1 ce -> wave=1; 16 ce -> 256; 32 ce -> 0; 48 ce -> -256; 64 ce -> 0 with sync=1 on the next clk.
REQ-029 mode=1, mode_ld at n=5 -> wave stays parabola until wrap, then mode_act=1. At n=8 -> wave=128; at n=40 -> -128.
REQ-030 Sawtooth -> wave=-256 at n=0, 0 at n=32, 248 at n=63. Square -> 256 at n=31 and -256 at n=32.
REQ-031 ce toggled randomly 50% over 3 periods -> no sample skipped or repeated versus the reference model; sync count = 3.
REQ-032 rst at n=20 in triangle mode with a pending mode_ld -> wave=0, mode_act=0, pending cleared; next ce -> wave=1.
